// File: rtl/prio_scan_encoder_if.sv
// Request/result handshake bundle for prio_scan_encoder.
// Carries req_valid/req_ready/req in, out_valid/out_ready/idx/rank/last/none out.
interface prio_scan_encoder_if #(
  parameter int N = 12,
  parameter int W = 4
) ();
  logic         req_valid;
  logic         req_ready;
  logic [N-1:0] req;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;
  logic [W-1:0] out_rank;
  logic         out_last;
  logic         out_none;

  modport master (
    output req_valid, req, out_ready,
    input  req_ready, out_valid,
    input  out_idx, out_rank, out_last, out_none
  );

  modport slave (
    input  req_valid, req, out_ready,
    output req_ready, out_valid,
    output out_idx, out_rank, out_last, out_none
  );
endinterface

// File: rtl/prio_scan_encoder.sv
// Sequential multi-winner priority encoder: latches a request, emits up to K indices.
// Ports: clk, reset_n (async low), abort (sync flush), bus (slave side of handshake if).
module prio_scan_encoder #(
  parameter int N         = 12,
  parameter int W         = 4,
  parameter int K         = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   abort,
  prio_scan_encoder_if.slave     bus
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic [W-1:0] KM1 = W'(K - 1);
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  state_t       state_q, state_d;
  logic [N-1:0] pending_q, pending_d;
  logic [W-1:0] rank_q, rank_d;
  logic         none_q, none_d;

  logic [W-1:0] win_idx;
  logic [N-1:0] win_mask;
  logic [N-1:0] rest;
  logic         last;
  logic         scan;

  function automatic logic [W-1:0] pick(input logic [N-1:0] v);
    pick = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < N; i++)
        if (v[i]) pick = W'(i);
    end else begin
      for (int i = N - 1; i >= 0; i--)
        if (v[i]) pick = W'(i);
    end
  endfunction

  always_comb begin
    scan     = (state_q == SCAN);
    win_idx  = pick(pending_q);
    win_mask = ONE << win_idx;
    rest     = pending_q & ~win_mask;
    last     = none_q | ~|rest | (rank_q == KM1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      rank_q    <= '0;
      none_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      rank_q    <= rank_d;
      none_q    <= none_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    rank_d    = rank_q;
    none_d    = none_q;
    if (abort) begin
      state_d   = IDLE;
      pending_d = '0;
      rank_d    = '0;
      none_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            state_d   = SCAN;
            pending_d = bus.req;
            rank_d    = '0;
            none_d    = ~|bus.req;
          end
        end
        SCAN: begin
          if (bus.out_ready) begin
            pending_d = rest;
            rank_d    = rank_q + 1'b1;
            // Final beat: drop any winners beyond K and park cleanly.
            if (last) begin
              state_d   = IDLE;
              pending_d = '0;
              rank_d    = '0;
              none_d    = 1'b0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are purely registered state; IDLE forces them to zero.
  always_comb begin
    bus.req_ready = ~scan;
    bus.out_valid = scan;
    bus.out_idx   = '0;
    bus.out_rank  = '0;
    bus.out_last  = 1'b0;
    bus.out_none  = 1'b0;
    if (scan) begin
      bus.out_idx  = none_q ? '0 : win_idx;
      bus.out_rank = rank_q;
      bus.out_last = last;
      bus.out_none = none_q;
    end
  end

endmodule

// File: tb/tb_prio_scan_encoder.sv
// Directed bench for prio_scan_encoder: two instances (default, K=4 LSB-first).
// Inputs driven and outputs sampled on the falling edge.
module tb_prio_scan_encoder;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic abort_a = 1'b0;
  logic abort_b = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  prio_scan_encoder_if #(.N(12), .W(4)) ia ();
  prio_scan_encoder_if #(.N(12), .W(4)) ib ();

  prio_scan_encoder #(.N(12), .W(4), .K(2), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n), .abort(abort_a), .bus(ia)
  );

  prio_scan_encoder #(.N(12), .W(4), .K(4), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .abort(abort_b), .bus(ib)
  );

  task automatic test_reset();
    ia.req_valid = 0; ia.req = '0; ia.out_ready = 1;
    ib.req_valid = 0; ib.req = '0; ib.out_ready = 1;
    reset_n = 0;
    @(negedge clk);
    n_checks++;
    if ({ia.out_valid, ia.req_ready, ia.out_idx, ia.out_rank,
         ia.out_last, ia.out_none} !== {1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_a: v=%b r=%b i=%0d k=%0d l=%b n=%b want 0 1 0 0 0 0",
               ia.out_valid, ia.req_ready, ia.out_idx, ia.out_rank,
               ia.out_last, ia.out_none);
    end
    n_checks++;
    if ({ib.out_valid, ib.req_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_b: v=%b r=%b want 0 1", ib.out_valid, ib.req_ready);
    end
    reset_n = 1;
    @(negedge clk);
  endtask

  task automatic test_msb_k2();
    ia.out_ready = 1;
    ia.req_valid = 1; ia.req = 12'h842;
    @(negedge clk);
    ia.req_valid = 0;
    n_checks++;
    if ({ia.out_valid, ia.req_ready, ia.out_idx, ia.out_rank, ia.out_last}
        !== {1'b1, 1'b0, 4'd11, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL msb_beat1: v=%b r=%b i=%0d k=%0d l=%b want 1 0 11 0 0",
               ia.out_valid, ia.req_ready, ia.out_idx, ia.out_rank, ia.out_last);
    end
    @(negedge clk);
    n_checks++;
    if ({ia.out_valid, ia.out_idx, ia.out_rank, ia.out_last}
        !== {1'b1, 4'd6, 4'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL msb_beat2: v=%b i=%0d k=%0d l=%b want 1 6 1 1",
               ia.out_valid, ia.out_idx, ia.out_rank, ia.out_last);
    end
    @(negedge clk);
    n_checks++;
    if ({ia.out_valid, ia.req_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL msb_idle: v=%b r=%b want 0 1", ia.out_valid, ia.req_ready);
    end
  endtask

  task automatic test_lsb_k4();
    logic [3:0] exp_idx [3];
    exp_idx[0] = 4'd0; exp_idx[1] = 4'd5; exp_idx[2] = 4'd7;
    ib.out_ready = 1;
    ib.req_valid = 1; ib.req = 12'h0A1;
    @(negedge clk);
    ib.req_valid = 0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({ib.out_valid, ib.out_idx, ib.out_rank, ib.out_last}
          !== {1'b1, exp_idx[i], 4'(i), (i == 2)}) begin
        n_fail++;
        $display("FAIL lsb_beat%0d: v=%b i=%0d k=%0d l=%b want 1 %0d %0d %0d",
                 i, ib.out_valid, ib.out_idx, ib.out_rank, ib.out_last,
                 exp_idx[i], i, (i == 2));
      end
      @(negedge clk);
    end
    n_checks++;
    if (ib.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lsb_idle: v=%b want 0", ib.out_valid);
    end
  endtask

  task automatic test_zero();
    ia.out_ready = 1;
    ia.req_valid = 1; ia.req = 12'h000;
    @(negedge clk);
    ia.req_valid = 0;
    n_checks++;
    if ({ia.out_valid, ia.out_none, ia.out_idx, ia.out_rank, ia.out_last}
        !== {1'b1, 1'b1, 4'd0, 4'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL zero_beat: v=%b n=%b i=%0d k=%0d l=%b want 1 1 0 0 1",
               ia.out_valid, ia.out_none, ia.out_idx, ia.out_rank, ia.out_last);
    end
    @(negedge clk);
    n_checks++;
    if ({ia.out_valid, ia.req_ready, ia.out_none} !== 3'b010) begin
      n_fail++;
      $display("FAIL zero_idle: v=%b r=%b n=%b want 0 1 0",
               ia.out_valid, ia.req_ready, ia.out_none);
    end
  endtask

  task automatic test_backpressure();
    ia.out_ready = 0;
    ia.req_valid = 1; ia.req = 12'h842;
    @(negedge clk);
    ia.req_valid = 0;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({ia.out_valid, ia.out_idx, ia.out_rank, ia.out_last}
          !== {1'b1, 4'd11, 4'd0, 1'b0}) begin
        n_fail++;
        $display("FAIL bp_hold%0d: v=%b i=%0d k=%0d l=%b want 1 11 0 0",
                 i, ia.out_valid, ia.out_idx, ia.out_rank, ia.out_last);
      end
      @(negedge clk);
    end
    n_checks++;
    if ({ia.out_idx, ia.out_rank} !== {4'd11, 4'd0}) begin
      n_fail++;
      $display("FAIL bp_first: i=%0d k=%0d want 11 0", ia.out_idx, ia.out_rank);
    end
    ia.out_ready = 1;
    @(negedge clk);
    n_checks++;
    if ({ia.out_valid, ia.out_idx, ia.out_rank, ia.out_last}
        !== {1'b1, 4'd6, 4'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL bp_second: v=%b i=%0d k=%0d l=%b want 1 6 1 1",
               ia.out_valid, ia.out_idx, ia.out_rank, ia.out_last);
    end
    @(negedge clk);
    n_checks++;
    if (ia.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_done: v=%b want 0", ia.out_valid);
    end
  endtask

  task automatic test_abort();
    ia.out_ready = 1;
    ia.req_valid = 1; ia.req = 12'hFFF;
    @(negedge clk);
    abort_a = 1;
    ia.req = 12'h00F;
    @(negedge clk);
    abort_a = 0;
    ia.req_valid = 0;
    n_checks++;
    if ({ia.out_valid, ia.req_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL abort_scan: v=%b r=%b want 0 1", ia.out_valid, ia.req_ready);
    end
    abort_a = 1;
    ia.req_valid = 1; ia.req = 12'h00F;
    @(negedge clk);
    abort_a = 0;
    ia.req_valid = 0;
    n_checks++;
    if ({ia.out_valid, ia.req_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL abort_idle: v=%b r=%b want 0 1", ia.out_valid, ia.req_ready);
    end
    ia.req_valid = 1; ia.req = 12'h030;
    @(negedge clk);
    ia.req_valid = 0;
    n_checks++;
    if ({ia.out_valid, ia.out_idx, ia.out_rank, ia.out_last}
        !== {1'b1, 4'd5, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL abort_next1: v=%b i=%0d k=%0d l=%b want 1 5 0 0",
               ia.out_valid, ia.out_idx, ia.out_rank, ia.out_last);
    end
    @(negedge clk);
    n_checks++;
    if ({ia.out_idx, ia.out_rank, ia.out_last} !== {4'd4, 4'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL abort_next2: i=%0d k=%0d l=%b want 4 1 1",
               ia.out_idx, ia.out_rank, ia.out_last);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    ia.out_ready = 1;
    ia.req_valid = 1; ia.req = 12'h842;
    @(negedge clk);
    ia.req_valid = 0;
    #2 reset_n = 0;
    #1;
    n_checks++;
    if ({ia.out_valid, ia.req_ready, ia.out_idx, ia.out_rank}
        !== {1'b0, 1'b1, 4'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL rst_mid: v=%b r=%b i=%0d k=%0d want 0 1 0 0",
               ia.out_valid, ia.req_ready, ia.out_idx, ia.out_rank);
    end
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    ia.req_valid = 1; ia.req = 12'h001;
    @(negedge clk);
    ia.req_valid = 0;
    n_checks++;
    if ({ia.out_valid, ia.out_idx, ia.out_rank, ia.out_last, ia.out_none}
        !== {1'b1, 4'd0, 4'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_after: v=%b i=%0d k=%0d l=%b n=%b want 1 0 0 1 0",
               ia.out_valid, ia.out_idx, ia.out_rank, ia.out_last, ia.out_none);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    ia.out_ready = 1;
    ia.req_valid = 1; ia.req = 12'h003;
    @(negedge clk);
    ia.req = 12'h800;
    n_checks++;
    if ({ia.req_ready, ia.out_idx, ia.out_rank, ia.out_last}
        !== {1'b0, 4'd1, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_beat1: r=%b i=%0d k=%0d l=%b want 0 1 0 0",
               ia.req_ready, ia.out_idx, ia.out_rank, ia.out_last);
    end
    @(negedge clk);
    n_checks++;
    if ({ia.out_idx, ia.out_rank, ia.out_last} !== {4'd0, 4'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL b2b_beat2: i=%0d k=%0d l=%b want 0 1 1",
               ia.out_idx, ia.out_rank, ia.out_last);
    end
    @(negedge clk);
    n_checks++;
    if ({ia.out_valid, ia.req_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL b2b_gap: v=%b r=%b want 0 1", ia.out_valid, ia.req_ready);
    end
    @(negedge clk);
    ia.req_valid = 0;
    n_checks++;
    if ({ia.out_valid, ia.out_idx, ia.out_rank, ia.out_last}
        !== {1'b1, 4'd11, 4'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL b2b_next: v=%b i=%0d k=%0d l=%b want 1 11 0 1",
               ia.out_valid, ia.out_idx, ia.out_rank, ia.out_last);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_msb_k2();
    test_lsb_k4();
    test_zero();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prio_scan_encoder.md
Name: prio_scan_encoder

Overview:
Parametrised multi-winner priority encoder. Latches an N-bit request vector through a valid/ready handshake, then emits the indices of up to K set bits, one per output beat, in priority order. The scan direction is selectable. This block replaces fixed two-encoder-plus-decoder chains with a single sequential scanner that supports a configurable winner count and output back-pressure.

Parameters:
N, 12, request vector width (2..64)
W, 4, index/rank width; must satisfy 2^W >= N and 2^W >= K
K, 2, maximum winners emitted per request (1..N)
MSB_FIRST, 1, 1 = highest set index wins first; 0 = lowest set index wins first

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
abort  input  1  synchronous flush; returns the block to IDLE
req_valid  input  1  request vector valid
req_ready  output  1  block can accept a request
req  input  N  request vector; bit i requests index i
out_valid  output  1  out_idx/out_rank/out_last/out_none valid
out_ready  input  1  downstream accepts the current beat
out_idx  output  W  index of the current winner
out_rank  output  W  winner ordinal: 0 = first winner, 1 = second, ...
out_last  output  1  final beat for this request
out_none  output  1  request vector was all-zero

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset values: state=IDLE, pending=0, rank=0, none_r=0, out_valid=0, req_ready=1. out_idx, out_rank, out_last and out_none are all 0.
- State machine has two states, IDLE and SCAN.
- IDLE:
  - req_ready=1 and out_valid=0.
  - On req_valid=1, pending<=req, rank<=0, none_r<=(req==0), next state SCAN.
- SCAN:
  - req_ready=0 and out_valid=1.
  - out_idx is the priority encode of the registered pending vector: highest set bit if MSB_FIRST=1, lowest set bit otherwise.
  - out_rank=rank and out_none=none_r.
  - out_last=1 when any of these holds: none_r=1; pending with the winner bit cleared is 0; rank==K-1.
- Latency: a request accepted at edge t presents its first beat after edge t (valid in cycle t+1). Later beats follow one per cycle while out_ready=1.
- Output handshake, when out_valid and out_ready are both 1 at an edge:
  - Clear the winner bit in pending and set rank<=rank+1.
  - If out_last=1, go to IDLE.
- Back-pressure: while out_valid=1 and out_ready=0, all outputs hold stable. No beat is dropped or duplicated.
- All-zero request: exactly one beat with out_none=1, out_idx=0, out_rank=0, out_last=1.
- K-limit: bits that remain set after K winners are discarded when the block returns to IDLE.
- No overlap: one IDLE cycle always separates requests, so maximum throughput is one request per (beats+1) cycles. Requests offered while req_ready=0 are ignored, not queued.
- abort=1 at an edge forces IDLE, pending=0, rank=0, none_r=0, and has priority over both handshakes.
  - abort is ignored for acceptance: a request offered in the same cycle as abort is not accepted.
  - req_ready returns to 1 in the next cycle.
- Reset asserted mid-scan: outputs go to their reset values immediately (asynchronous), and the in-flight request is lost.
- Combinational paths: out_idx and out_last depend only on registers. No input-to-output combinational path exists except through the handshake state.

Test Plan:
- Defaults (N=12, K=2, MSB_FIRST=1), req=12'h842 accepted with out_ready held at 1 -> beat 1: out_idx=11, out_rank=0, out_last=0; beat 2: out_idx=6, out_rank=1, out_last=1; req_ready=1 in the following cycle. Bit 1 is never emitted.
- K=4, MSB_FIRST=0, req=12'h0A1 -> out_idx sequence 0, 5, 7, with out_last=1 on idx 7 (only 3 bits set).
- req=12'h000 -> single beat with out_none=1, out_idx=0, out_last=1; back to IDLE after it.
- req=12'h842, out_ready=0 for 5 cycles after out_valid rises -> out_idx=11 and out_rank=0 stable throughout. Release out_ready -> idx 11 then idx 6, no repeats.
- abort pulsed on the first SCAN cycle of req=12'hFFF while req_valid=1 with a new vector -> the new vector is not accepted; out_valid=0 and req_ready=1 next cycle; the following request scans from rank 0.
- reset_n driven low mid-scan, asynchronously to clk -> out_valid=0 and req_ready=1 before the next edge; after release, req=12'h001 -> out_idx=0, out_rank=0, out_last=1.
